// File: rtl/mopshub_init_pkg.sv
// Shared types and sizing helpers for the MOPSHUB bus power-up / trim sequencer.
package mopshub_init_pkg;

  // Width of every bus index in the sequencer (covers up to 32 buses).
  localparam int BUS_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    POWER_ON,
    SETTLE,
    TRIM_REQ,
    TRIM_WAIT,
    NEXT,
    DONE
  } init_state_t;

  // Counter width able to hold (cycles-1); never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mopshub_down_counter.sv
// Loadable down counter that stops at zero; used for settle and trim timeouts.
module mopshub_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mopshub_bus_init_seq.sv
// Walks every CAN bus: power enable, settle, optional oscillator trim, then sign-on.
module mopshub_bus_init_seq
  import mopshub_init_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int TRIM_TIMEOUT  = 65535,
  parameter int NBUS_MAX      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_init,
  input  logic [BUS_IDX_W-1:0] n_buses,
  input  logic                 osc_auto_trim,
  input  logic                 end_trim_bus,
  output logic                 set_power_init,
  output logic [BUS_IDX_W-1:0] power_bus_cnt,
  output logic                 start_trim,
  output logic                 end_power_init,
  output logic                 sign_on_sig,
  output logic                 busy,
  output logic [NBUS_MAX-1:0]  timeout_flags
);

  localparam int SETTLE_W = cnt_width(SETTLE_CYCLES);
  localparam int TO_W     = cnt_width(TRIM_TIMEOUT);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]      TO_LOAD     = TO_W'(TRIM_TIMEOUT - 1);
  localparam logic [BUS_IDX_W-1:0] LAST_MAX    = BUS_IDX_W'(NBUS_MAX - 1);

  init_state_t          state, next_state;
  logic [BUS_IDX_W-1:0] last_bus;
  logic                 trim_en;
  logic                 settle_zero;
  logic                 to_zero;
  logic                 start_accept;
  logic                 trim_expired;

  assign start_accept = (state == IDLE) && start_init;
  // An ack in the final timeout cycle wins over the expiry.
  assign trim_expired = (state == TRIM_WAIT) && to_zero && !end_trim_bus;

  mopshub_down_counter #(.WIDTH(SETTLE_W)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == POWER_ON),
    .en       (state == SETTLE),
    .load_val (SETTLE_LOAD),
    .zero     (settle_zero)
  );

  mopshub_down_counter #(.WIDTH(TO_W)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == TRIM_REQ),
    .en       (state == TRIM_WAIT),
    .load_val (TO_LOAD),
    .zero     (to_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic for the per-bus walk.
  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE:      if (start_init) next_state = POWER_ON;
      POWER_ON:  next_state = SETTLE;
      SETTLE:    if (settle_zero) next_state = trim_en ? TRIM_REQ : NEXT;
      TRIM_REQ:  next_state = TRIM_WAIT;
      TRIM_WAIT: if (end_trim_bus || to_zero) next_state = NEXT;
      NEXT:      next_state = (power_bus_cnt == last_bus) ? DONE : POWER_ON;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Registered outputs, run configuration and per-bus bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_power_init <= 1'b0;
      start_trim     <= 1'b0;
      end_power_init <= 1'b0;
      sign_on_sig    <= 1'b0;
      busy           <= 1'b0;
      power_bus_cnt  <= '0;
      timeout_flags  <= '0;
      last_bus       <= '0;
      trim_en        <= 1'b0;
    end else begin
      set_power_init <= (next_state == POWER_ON);
      start_trim     <= (next_state == TRIM_REQ);
      end_power_init <= (next_state == DONE);
      sign_on_sig    <= (state == DONE);
      busy           <= (next_state != IDLE);

      if (start_accept) begin
        last_bus      <= (n_buses > LAST_MAX) ? LAST_MAX : n_buses;
        trim_en       <= osc_auto_trim;
        power_bus_cnt <= '0;
        timeout_flags <= '0;
      end

      // Compare before incrementing so the index never wraps past last_bus.
      if ((state == NEXT) && (power_bus_cnt != last_bus)) begin
        power_bus_cnt <= power_bus_cnt + 1'b1;
      end

      if (trim_expired) begin
        for (int i = 0; i < NBUS_MAX; i++) begin
          if (power_bus_cnt == BUS_IDX_W'(i)) timeout_flags[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mopshub_bus_init_seq.sv
// Directed bench for mopshub_bus_init_seq with an event scoreboard.
module tb_mopshub_bus_init_seq;

  localparam int S = 4;   // SETTLE_CYCLES
  localparam int T = 20;  // TRIM_TIMEOUT

  localparam logic [2:0] K_SPI  = 3'd1;  // set_power_init pulse
  localparam logic [2:0] K_TRIM = 3'd2;  // start_trim pulse
  localparam logic [2:0] K_EPI  = 3'd3;  // end_power_init pulse
  localparam logic [2:0] K_SOS  = 3'd4;  // sign_on_sig pulse

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  bus;
    logic [15:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_init;
  logic [4:0]  n_buses;
  logic        osc_auto_trim;
  logic        end_trim_bus;
  logic        set_power_init;
  logic [4:0]  power_bus_cnt;
  logic        start_trim;
  logic        end_power_init;
  logic        sign_on_sig;
  logic        busy;
  logic [15:0] timeout_flags;

  int  n_vec = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  int  ack_dly[16];  // cycles from start_trim to ack per bus; 0 = never ack

  mopshub_bus_init_seq #(
    .SETTLE_CYCLES (S),
    .TRIM_TIMEOUT  (T),
    .NBUS_MAX      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_init     (start_init),
    .n_buses        (n_buses),
    .osc_auto_trim  (osc_auto_trim),
    .end_trim_bus   (end_trim_bus),
    .set_power_init (set_power_init),
    .power_bus_cnt  (power_bus_cnt),
    .start_trim     (start_trim),
    .end_power_init (end_power_init),
    .sign_on_sig    (sign_on_sig),
    .busy           (busy),
    .timeout_flags  (timeout_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] all_outs();
    return {set_power_init, power_bus_cnt, start_trim, end_power_init,
            sign_on_sig, busy, timeout_flags};
  endfunction

  task automatic push_ev(input logic [2:0] kind, input int bus, input int cyc);
    ev_t e;
    e.kind = kind;
    e.bus  = 5'(bus);
    e.cyc  = 16'(cyc);
    exp_q.push_back(e);
  endtask

  // Compare an observed pulse against the oldest expected event.
  task automatic pop_cmp(input logic [2:0] kind, input string tag, input int cyc);
    ev_t obs;
    ev_t exp;
    obs.kind = kind;
    obs.bus  = power_bus_cnt;
    obs.cyc  = 16'(cyc);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check(tag, 64'(obs), 64'(exp));
  endtask

  // Cycle 1 is the cycle after start_init is sampled (POWER_ON of bus 0).
  task automatic build_model(input logic [4:0] nb, input logic trim);
    int last;
    int t;
    int tn;
    int w;
    last = (nb > 5'd15) ? 15 : int'(nb);
    t = 1;
    for (int b = 0; b <= last; b++) begin
      push_ev(K_SPI, b, t);
      tn = t + S + 1;
      if (trim) begin
        push_ev(K_TRIM, b, tn);
        w  = (ack_dly[b] == 0) ? T : ack_dly[b];
        tn = tn + 1 + w;
      end
      t = tn + 1;
    end
    push_ev(K_EPI, last, t);
    push_ev(K_SOS, last, t + 1);
  endtask

  // Start one sequence and track it until sign-on; optionally abort at a bus's trim request.
  task automatic run_seq(input string name, input logic [4:0] nb, input logic trim,
                         input int abort_bus, input int restart_cyc,
                         input logic [15:0] exp_flags);
    int   cyc;
    int   ack_cyc;
    logic done;
    logic busy_bad;
    exp_q.delete();
    build_model(nb, trim);
    n_buses       = nb;
    osc_auto_trim = trim;
    start_init    = 1'b1;
    @(negedge clk);
    start_init    = 1'b0;
    n_buses       = ~nb;    // must not be re-sampled mid-run
    osc_auto_trim = ~trim;
    cyc      = 1;
    ack_cyc  = -1;
    done     = 1'b0;
    busy_bad = 1'b0;
    while (!done && cyc <= 2000) begin
      if (set_power_init) pop_cmp(K_SPI, {name, "_power"}, cyc);
      if (start_trim) begin
        pop_cmp(K_TRIM, {name, "_trim"}, cyc);
        if (int'(power_bus_cnt) == abort_bus) begin
          exp_q.delete();
          return;
        end
        if (power_bus_cnt < 5'd16 && ack_dly[power_bus_cnt[3:0]] != 0)
          ack_cyc = cyc + ack_dly[power_bus_cnt[3:0]];
      end
      if (end_power_init) pop_cmp(K_EPI, {name, "_end_power"}, cyc);
      if (sign_on_sig) begin
        pop_cmp(K_SOS, {name, "_sign_on"}, cyc);
        done = 1'b1;
        check({name, "_busy_low"}, 64'(busy), 64'(1'b0));
        check({name, "_flags"}, 64'(timeout_flags), 64'(exp_flags));
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
      end_trim_bus = (cyc == ack_cyc);
      start_init   = (cyc == restart_cyc);
      @(negedge clk);
      cyc++;
    end
    end_trim_bus = 1'b0;
    start_init   = 1'b0;
    check({name, "_completed"}, 64'(done), 64'(1'b1));
    check({name, "_busy_held"}, 64'(busy_bad), 64'(1'b0));
    check({name, "_events_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [25:0] idle_or;
    rst           = 1'b0;
    start_init    = 1'b0;
    n_buses       = '0;
    osc_auto_trim = 1'b0;
    end_trim_bus  = 1'b0;
    for (int i = 0; i < 16; i++) ack_dly[i] = 10;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All 16 buses, power only: pulses 6 cycles apart.
    run_seq("all_no_trim", 5'd15, 1'b0, -1, -1, 16'h0000);

    // Three buses with trim, each acked 10 cycles after its request.
    run_seq("trim_ack", 5'd2, 1'b1, -1, -1, 16'h0000);

    // Bus 1 never acks: full timeout, flag bit 1, sequence still completes.
    ack_dly[1] = 0;
    run_seq("trim_timeout", 5'd3, 1'b1, -1, -1, 16'h0002);

    // Ack on the last timeout cycle of bus 0 wins; start_init re-pulsed mid-run.
    ack_dly[0] = T;
    ack_dly[1] = 10;
    run_seq("ack_on_expiry", 5'd1, 1'b1, -1, 8, 16'h0000);
    ack_dly[0] = 10;

    // Out-of-range bus count clamps to 16 buses.
    run_seq("clamp_31", 5'd31, 1'b0, -1, -1, 16'h0000);

    // Single bus: end_power_init in cycle S+3.
    run_seq("single_bus", 5'd0, 1'b0, -1, -1, 16'h0000);

    // Reset in the trim wait of bus 7.
    run_seq("pre_reset", 5'd15, 1'b1, 7, -1, 16'h0000);
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'(1'b1));
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", 64'(all_outs()), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    idle_or = '0;
    repeat (6) begin
      @(negedge clk);
      idle_or = idle_or | all_outs();
    end
    check("idle_after_reset", 64'(idle_or), 64'(0));
    run_seq("restart", 5'd1, 1'b0, -1, -1, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
